// File: rtl/ahb_slave_mem.sv
// AHB slave with a word-addressed on-chip memory, programmable wait states and
// the two-cycle ERROR response for misaligned or out-of-range accesses.
module ahb_slave_mem #(
   parameter int unsigned MEM_WORDS = 256,
   parameter int unsigned WAIT_CYC  = 0
) (
   input  logic        H_clk,
   input  logic        H_resetn,
   input  logic        H_sel,
   input  logic        H_ready,
   input  logic [1:0]  H_trans,
   input  logic        H_write,
   input  logic [2:0]  H_burst,
   input  logic [31:0] H_addr,
   input  logic [31:0] H_wdata,
   output logic        H_readyout,
   output logic [1:0]  H_resp,
   output logic [31:0] H_rdata
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [2:0] {StIdle, StWait, StLast, StErr1, StErr2} state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            wr_q, wr_d;
   logic            accept, addr_err;
   logic [31:0]     mem [MEM_WORDS];

   // Burst type and the NONSEQ/SEQ distinction do not affect this slave.
   logic unused_inputs;
   assign unused_inputs = ^{H_burst, H_trans[0]};

   assign accept   = H_sel & H_ready & H_trans[1];
   assign addr_err = (H_addr[1:0] != 2'b00) | ({2'b00, H_addr[31:2]} >= MEM_WORDS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      unique case (state_q)
         StIdle, StLast, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               idx_d = H_addr[AW+1:2];
               wr_d  = H_write;
               if (addr_err) begin
                  state_d = StErr1;
               end else if (WAIT_CYC == 0) begin
                  state_d = StLast;
               end else begin
                  state_d = StWait;
                  cnt_d   = 3'(WAIT_CYC - 1);
               end
            end
         end
         StWait: begin
            if (cnt_q == 3'd0) state_d = StLast;
            else               cnt_d   = cnt_q - 3'd1;
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge H_clk or negedge H_resetn) begin
      if (!H_resetn) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
      end
   end

   // Reset forces StIdle, so a write caught mid data phase never commits.
   always_ff @(posedge H_clk) begin
      if (state_q == StLast && wr_q) mem[idx_q] <= H_wdata;
   end

   always_comb begin
      H_readyout = 1'b1;
      H_resp     = 2'b00;
      H_rdata    = '0;
      unique case (state_q)
         StWait:  H_readyout = 1'b0;
         StErr1: begin
            H_readyout = 1'b0;
            H_resp     = 2'b01;
         end
         StErr2:  H_resp = 2'b01;
         StLast:  if (!wr_q) H_rdata = mem[idx_q];
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: one zero-wait and one two-wait instance exercised in turn.
module tb_ahb_slave_mem;

   logic        H_clk = 1'b0;
   logic        H_resetn;
   logic        sel0, sel2;
   logic [1:0]  trans;
   logic        write;
   logic [2:0]  burst;
   logic [31:0] addr, wdata;
   logic        rdy0, rdy2;
   logic [1:0]  resp0, resp2;
   logic [31:0] rdata0, rdata2;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

   always #5 H_clk = ~H_clk;

   ahb_slave_mem #(.MEM_WORDS(256), .WAIT_CYC(0)) u_dut0 (
      .H_clk(H_clk), .H_resetn(H_resetn), .H_sel(sel0), .H_ready(rdy0), .H_trans(trans),
      .H_write(write), .H_burst(burst), .H_addr(addr), .H_wdata(wdata),
      .H_readyout(rdy0), .H_resp(resp0), .H_rdata(rdata0)
   );

   ahb_slave_mem #(.MEM_WORDS(256), .WAIT_CYC(2)) u_dut2 (
      .H_clk(H_clk), .H_resetn(H_resetn), .H_sel(sel2), .H_ready(rdy2), .H_trans(trans),
      .H_write(write), .H_burst(burst), .H_addr(addr), .H_wdata(wdata),
      .H_readyout(rdy2), .H_resp(resp2), .H_rdata(rdata2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge H_clk);
      #1;
   endtask

   task automatic ap(input logic [1:0] t, input logic w, input logic [31:0] a);
      trans = t;
      write = w;
      addr  = a;
   endtask

   // Check readyout/resp/rdata of one instance in one call.
   task automatic chk3(input string tag, input logic r, input logic [1:0] rs, input logic [31:0] d,
                       input logic er, input logic [1:0] ers, input logic [31:0] ed);
      chk({tag, ".rdy"}, {31'd0, r}, {31'd0, er});
      chk({tag, ".resp"}, {30'd0, rs}, {30'd0, ers});
      chk({tag, ".rdata"}, d, ed);
   endtask

   initial begin
      H_resetn = 1'b0;
      sel0 = 1'b0; sel2 = 1'b0; burst = 3'b000;
      ap(IDLE, 1'b0, 32'h0);
      wdata = 32'h0;
      #12;
      chk3("rst0", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'h0);
      chk3("rst2", rdy2, resp2, rdata2, 1'b1, 2'b00, 32'h0);
      H_resetn = 1'b1;

      // 1: zero-wait write then back-to-back read of the same word
      sel0 = 1'b1;
      ap(NSEQ, 1'b1, 32'h10);
      tick();
      wdata = 32'hDEADBEEF;
      chk3("t1_wr", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'h0);
      ap(NSEQ, 1'b0, 32'h10);
      tick();
      chk3("t1_rd", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'hDEADBEEF);
      // 3: boundary word 255, word 0, then out-of-range and misaligned writes
      ap(NSEQ, 1'b1, 32'h3FC);
      tick();
      wdata = 32'hA5A5A5A5;
      ap(NSEQ, 1'b1, 32'h000);
      tick();
      wdata = 32'h11111111;
      ap(NSEQ, 1'b1, 32'h400);
      tick();
      wdata = 32'hFFFFFFFF;
      ap(IDLE, 1'b0, 32'h0);
      chk3("t3_err1", rdy0, resp0, rdata0, 1'b0, 2'b01, 32'h0);
      tick();
      chk3("t3_err2", rdy0, resp0, rdata0, 1'b1, 2'b01, 32'h0);
      ap(NSEQ, 1'b1, 32'h11);
      tick();
      chk3("t3_mis1", rdy0, resp0, rdata0, 1'b0, 2'b01, 32'h0);
      ap(IDLE, 1'b0, 32'h0);
      tick();
      chk3("t3_mis2", rdy0, resp0, rdata0, 1'b1, 2'b01, 32'h0);
      ap(NSEQ, 1'b0, 32'h3FC);
      tick();
      chk("t3_rd255", rdata0, 32'hA5A5A5A5);
      ap(NSEQ, 1'b0, 32'h000);
      tick();
      chk("t3_rd0", rdata0, 32'h11111111);
      ap(NSEQ, 1'b0, 32'h010);
      tick();
      chk("t3_rd4", rdata0, 32'hDEADBEEF);

      // 4: INCR4 writes with a BUSY after beat 1, then INCR4 reads
      burst = 3'b011;
      ap(NSEQ, 1'b1, 32'h20);
      tick();
      wdata = 32'hC0DE0020;
      ap(SEQ, 1'b1, 32'h24);
      tick();
      wdata = 32'hC0DE0024;
      ap(BUSY, 1'b1, 32'h28);
      tick();
      wdata = 32'hBAD0BAD0;
      chk3("t4_busy", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'h0);
      ap(SEQ, 1'b1, 32'h28);
      tick();
      wdata = 32'hC0DE0028;
      ap(SEQ, 1'b1, 32'h2C);
      tick();
      wdata = 32'hC0DE002C;
      ap(NSEQ, 1'b0, 32'h20);
      tick();
      chk3("t4_r0", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'hC0DE0020);
      ap(SEQ, 1'b0, 32'h24);
      tick();
      chk3("t4_r1", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'hC0DE0024);
      ap(SEQ, 1'b0, 32'h28);
      tick();
      chk3("t4_r2", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'hC0DE0028);
      ap(SEQ, 1'b0, 32'h2C);
      tick();
      chk3("t4_r3", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'hC0DE002C);
      burst = 3'b000;

      // 5: deselected NONSEQ write leaves the word alone
      ap(NSEQ, 1'b1, 32'h30);
      tick();
      wdata = 32'h30303030;
      ap(IDLE, 1'b0, 32'h0);
      tick();
      sel0 = 1'b0;
      ap(NSEQ, 1'b1, 32'h30);
      tick();
      wdata = 32'hFFFF0000;
      chk3("t5_desel", rdy0, resp0, rdata0, 1'b1, 2'b00, 32'h0);
      ap(IDLE, 1'b0, 32'h0);
      tick();
      sel0 = 1'b1;
      ap(NSEQ, 1'b0, 32'h30);
      tick();
      chk("t5_rd", rdata0, 32'h30303030);
      ap(IDLE, 1'b0, 32'h0);
      tick();
      chk("t5_idle", rdata0, 32'h0);
      sel0 = 1'b0;

      // 2: two wait states per data phase
      sel2 = 1'b1;
      ap(NSEQ, 1'b1, 32'h04);
      tick();
      wdata = 32'h12345678;
      ap(IDLE, 1'b0, 32'h0);
      chk("t2_w_wait1", {31'd0, rdy2}, 32'd0);
      tick();
      chk("t2_w_wait2", {31'd0, rdy2}, 32'd0);
      tick();
      chk3("t2_w_last", rdy2, resp2, rdata2, 1'b1, 2'b00, 32'h0);
      ap(NSEQ, 1'b0, 32'h04);
      tick();
      ap(IDLE, 1'b0, 32'h0);
      chk3("t2_r_wait1", rdy2, resp2, rdata2, 1'b0, 2'b00, 32'h0);
      tick();
      chk("t2_r_wait2", {31'd0, rdy2}, 32'd0);
      tick();
      chk3("t2_r_last", rdy2, resp2, rdata2, 1'b1, 2'b00, 32'h12345678);

      // 6: reset during the wait phase of a write drops that write
      ap(NSEQ, 1'b1, 32'h08);
      tick();
      wdata = 32'h55AA55AA;
      ap(IDLE, 1'b0, 32'h0);
      tick();
      tick();
      ap(NSEQ, 1'b1, 32'h08);
      tick();
      wdata = 32'hDEAD0000;
      ap(IDLE, 1'b0, 32'h0);
      chk("t6_wait", {31'd0, rdy2}, 32'd0);
      #2;
      H_resetn = 1'b0;
      #1;
      chk3("t6_rst", rdy2, resp2, rdata2, 1'b1, 2'b00, 32'h0);
      tick();
      tick();
      H_resetn = 1'b1;
      ap(NSEQ, 1'b0, 32'h08);
      tick();
      ap(IDLE, 1'b0, 32'h0);
      tick();
      tick();
      chk3("t6_rd", rdy2, resp2, rdata2, 1'b1, 2'b00, 32'h55AA55AA);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB slave endpoint for the transfers issued by the AHB master wrapper: a word-addressed on-chip memory behind the bus decoder. It samples address-phase controls when selected, inserts a configurable number of wait states, and completes reads/writes with OKAY. Out-of-range or misaligned accesses get the two-cycle ERROR response. It sits on the slave side of the AHB fabric, fed by the decoder's H_sel and the global H_ready.

Parameters:
MEM_WORDS, 256, number of 32-bit words; valid word index 0..MEM_WORDS-1
WAIT_CYC, 0, wait states per OKAY data phase (0..7), H_readyout low for exactly WAIT_CYC cycles

Ports:
H_clk  input  1  bus clock, rising edge
H_resetn  input  1  asynchronous active-low reset
H_sel  input  1  slave select from decoder
H_ready  input  1  global HREADY (muxed); address phase is sampled only when 1
H_trans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
H_write  input  1  1 write, 0 read
H_burst  input  3  burst type; accepted but not used for addressing (every beat carries its own H_addr)
H_addr  input  32  byte address
H_wdata  input  32  write data, valid in data phase
H_readyout  output  1  this slave's HREADY
H_resp  output  2  00 OKAY, 01 ERROR
H_rdata  output  32  read data

Behaviour:
- One clock (H_clk); reset asynchronous, active-low (H_resetn).
- Reset values: state ST_IDLE, H_readyout=1, H_resp=00, H_rdata=0, wait counter 0, address/write registers 0. Memory contents are not reset.
- Accept = H_sel & H_ready & H_trans[1] (NONSEQ or SEQ). On accept, register word index H_addr[31:2], H_write, and err = (H_addr[1:0]!=0) | (H_addr[31:2] >= MEM_WORDS).
- H_sel & H_ready with IDLE/BUSY, or H_sel=0: no data phase; response stays OKAY, H_readyout=1, no memory effect.
- States:
  - ST_IDLE: no data phase; readyout=1, OKAY.
  - ST_WAIT: readyout=0, OKAY; counter counts down. Leaves to ST_LAST after WAIT_CYC cycles in ST_WAIT.
  - ST_LAST: readyout=1, OKAY; final data-phase cycle.
  - ST_ERR1: readyout=0, resp=ERROR.
  - ST_ERR2: readyout=1, resp=ERROR.
- Transitions from ST_IDLE, ST_LAST, ST_ERR2:
  - On accept: err -> ST_ERR1; else WAIT_CYC==0 -> ST_LAST; else ST_WAIT with counter=WAIT_CYC-1.
  - No accept: ST_IDLE.
- ST_WAIT: counter==0 -> ST_LAST, else decrement. ST_ERR1 -> ST_ERR2 always. No accept is possible in ST_WAIT/ST_ERR1 because the global H_ready is low.
- Write commit: at the rising edge ending ST_LAST, mem[index] <= H_wdata. There is no write on an ERROR path.
- Read: in ST_LAST for a read, H_rdata = mem[index]. In all other states and for writes, H_rdata = 0.
- Pipelining: an accept in ST_LAST overlaps the next address phase with the current data phase; sustained zero-wait throughput is one beat per cycle.
- Read-after-write to the same word back-to-back returns the new data, because the write commits at the edge that starts the read's data phase.
- Wrap/boundary: index MEM_WORDS-1 is valid; MEM_WORDS and above give ERROR. Upper address bits are not aliased.
- Reset asserted mid data phase: immediate return to reset values; a pending write is dropped.

Test Plan:
1. WAIT_CYC=0: write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> write data phase readyout=1 with OKAY; next cycle H_rdata=0xDEADBEEF, readyout=1, OKAY.
2. WAIT_CYC=2: read @0x04 after write 0x12345678 -> readyout low for exactly 2 cycles, then high with H_rdata=0x12345678.
3. Address 0x400 (index 256, MEM_WORDS=256) write -> ERR1 (readyout=0, resp=01) then ERR2 (readyout=1, resp=01); subsequent read @0x400-4 is unaffected. Misaligned 0x11 behaves the same.
4. INCR4 burst writes 0x20/0x24/0x28/0x2C, one BUSY inserted after beat 2, then INCR4 reads -> BUSY cycle gives OKAY with no write; reads return the 4 written values at one beat per cycle.
5. H_sel=0 with NONSEQ @0x30 write -> no state change; a later read @0x30 returns the prior contents.
6. Assert H_resetn low during ST_WAIT of a write -> outputs return to reset values asynchronously; the target word is unchanged.
